// File: rtl/data_mem_pkg.sv
// Shared definitions for the byte-addressed data memory: funct3 codes, FSM states
// and the lane-enable / alignment helpers used by the store and load paths.
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    if (we) return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_B, F3_BU: byte_en = 4'b0001 << addr_lo;
      F3_H, F3_HU: byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
      F3_W:        byte_en = 4'b1111;
      default:     byte_en = 4'b0000;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: misaligned = addr_lo[0];
      F3_W:        misaligned = (addr_lo != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  endfunction

  // Drops the low address bits that a halfword or word access cannot use.
  function automatic logic [1:0] align_lo(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: align_lo = {addr_lo[1], 1'b0};
      F3_W:        align_lo = 2'b00;
      default:     align_lo = addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_load_align.sv
// Load result formatter: picks the addressed byte/halfword out of a captured
// memory word and sign- or zero-extends it according to funct3.
module data_mem_load_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata = {24'd0, byte_sel};
      F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata = {16'd0, half_sel};
      F3_W:    rdata = word;
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// MEM-stage data memory with RV32I load/store sizes, byte-lane writes, registered
// reads, configurable wait states and a valid/ready handshake. Optional macro
// MISALIGN_TRAP_EN turns misaligned halfword/word accesses into error responses.
module data_mem_lsu
  import data_mem_pkg::*;
#(
  parameter int DEPTH       = 128,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            state, state_next;
  logic [3:0]        wait_cnt;
  logic              accept;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        addr_lo;
  logic              err_now;
  logic [3:0]        be;
  logic [31:0]       wdata_rep;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       word_q;
  logic [2:0]        funct3_q;
  logic [1:0]        lo_q;
  logic              we_q;
  logic              err_q;
  logic [31:0]       load_data;
  logic              unused_addr;

  assign accept      = req_valid && req_ready;
  assign idx         = req_addr[2 +: IDX_W];
  assign unused_addr = ^req_addr;

`ifdef MISALIGN_TRAP_EN
  assign addr_lo = req_addr[1:0];
  assign err_now = !f3_legal(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
`else
  assign addr_lo = align_lo(req_funct3, req_addr[1:0]);
  assign err_now = !f3_legal(req_we, req_funct3);
`endif

  assign be = err_now ? 4'b0000 : byte_en(req_funct3, addr_lo);

  always_comb begin
    case (req_funct3)
      F3_B:    wdata_rep = {4{req_wdata[7:0]}};
      F3_H:    wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  // The array read is captured at the accept edge before that edge's own write.
  always_ff @(posedge clk) begin
    if (accept) begin
      word_q <= mem[idx];
      if (req_we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q <= 3'd0;
      lo_q     <= 2'd0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      funct3_q <= req_funct3;
      lo_q     <= addr_lo;
      we_q     <= req_we;
      err_q    <= err_now;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 wait_cnt <= 4'd0;
    else if (accept)                            wait_cnt <= WAIT_LOAD;
    else if (state == WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT:    if (wait_cnt == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  data_mem_load_align u_align (
    .word    (word_q),
    .funct3  (funct3_q),
    .addr_lo (lo_q),
    .rdata   (load_data)
  );

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    resp_err   = resp_valid && err_q;
    resp_rdata = (resp_valid && !we_q && !err_q) ? load_data : 32'd0;
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu: one instance with no wait states and one
// with three, driven by a linear sequence of directed load/store requests.
module tb_data_mem_lsu;
  import data_mem_pkg::*;

  localparam int WS_SLOW = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  data_mem_lsu #(.DEPTH(128), .ADDR_W(32), .WAIT_STATES(0)) u_fast (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_mem_lsu #(.DEPTH(128), .ADDR_W(32), .WAIT_STATES(WS_SLOW)) u_slow (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic check_output(input int d, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq({tag, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq({tag, " rdata"}, resp_rdata[d], e.rdata);
      check_eq({tag, " err"}, 32'(resp_err[d]), 32'(e.err));
    end
  endtask

  // Called right after the accept edge (#1 later); follows the request to its response.
  task automatic wait_resp(input int d, input string tag);
    int n;
    n = 0;
    while (resp_valid[d] !== 1'b1 && n < 40) begin
      check_eq({tag, " busy ready"}, 32'(req_ready[d]), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, " latency"}, 32'(n), (d == 1) ? 32'(WS_SLOW) : 32'd0);
    check_eq({tag, " resp ready"}, 32'(req_ready[d]), 32'd0);
    check_output(d, tag);
    @(posedge clk); #1;
    check_eq({tag, " strobe end"}, 32'(resp_valid[d]), 32'd0);
    check_eq({tag, " idle rdata"}, resp_rdata[d], 32'd0);
    check_eq({tag, " ready back"}, 32'(req_ready[d]), 32'd1);
  endtask

  task automatic drive(input int d, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
  endtask

  task automatic push_exp(input logic [31:0] rd, input logic err);
    exp_t e;
    e.rdata = rd;
    e.err   = err;
    sb.push_back(e);
  endtask

  task automatic apply_stimulus(input int d, input string tag, input logic we,
                                input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rd,
                                input logic exp_err);
    int n;
    push_exp(exp_rd, exp_err);
    drive(d, we, f3, addr, wdata);
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, " ready wait"}, 32'(n < 40), 32'd1);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    wait_resp(d, tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = 3'd0;
      req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("reset ready", 32'(req_ready[d]), 32'd1);
      check_eq("reset valid", 32'(resp_valid[d]), 32'd0);
      check_eq("reset rdata", resp_rdata[d], 32'd0);
      check_eq("reset err", 32'(resp_err[d]), 32'd0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] zero-wait word and lane accesses");
    apply_stimulus(0, "sw 10", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    apply_stimulus(0, "lw 10", 1'b0, F3_W, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
    apply_stimulus(0, "sw 20", 1'b1, F3_W, 32'h20, 32'h11223344, 32'd0, 1'b0);
    apply_stimulus(0, "sb 21", 1'b1, F3_B, 32'h21, 32'h123456AA, 32'd0, 1'b0);
    apply_stimulus(0, "lw 20", 1'b0, F3_W, 32'h20, 32'd0, 32'h1122AA44, 1'b0);
    apply_stimulus(0, "lb 21", 1'b0, F3_B, 32'h21, 32'd0, 32'hFFFFFFAA, 1'b0);
    apply_stimulus(0, "lbu 21", 1'b0, F3_BU, 32'h21, 32'd0, 32'h000000AA, 1'b0);
    apply_stimulus(0, "lb 20", 1'b0, F3_B, 32'h20, 32'd0, 32'h00000044, 1'b0);
    apply_stimulus(0, "lh 22", 1'b0, F3_H, 32'h22, 32'd0, 32'h00001122, 1'b0);
    apply_stimulus(0, "lh 20", 1'b0, F3_H, 32'h20, 32'd0, 32'hFFFFAA44, 1'b0);
    apply_stimulus(0, "lhu 20", 1'b0, F3_HU, 32'h20, 32'd0, 32'h0000AA44, 1'b0);
    apply_stimulus(0, "sh 22", 1'b1, F3_H, 32'h22, 32'hFFFFBEEF, 32'd0, 1'b0);
    apply_stimulus(0, "lw 20 sh", 1'b0, F3_W, 32'h20, 32'd0, 32'hBEEFAA44, 1'b0);
    apply_stimulus(0, "lw alias", 1'b0, F3_W, 32'h210, 32'd0, 32'hDEADBEEF, 1'b0);

    $display("[TB] illegal funct3");
    apply_stimulus(0, "sw 30", 1'b1, F3_W, 32'h30, 32'h55667788, 32'd0, 1'b0);
    apply_stimulus(0, "ld f3=3", 1'b0, 3'd3, 32'h30, 32'd0, 32'd0, 1'b1);
    apply_stimulus(0, "st f3=7", 1'b1, 3'd7, 32'h30, 32'hFFFFFFFF, 32'd0, 1'b1);
    apply_stimulus(0, "st f3=4", 1'b1, 3'd4, 32'h30, 32'hFFFFFFFF, 32'd0, 1'b1);
    apply_stimulus(0, "lw 30", 1'b0, F3_W, 32'h30, 32'd0, 32'h55667788, 1'b0);

    $display("[TB] misaligned accesses");
`ifdef MISALIGN_TRAP_EN
    apply_stimulus(0, "lw 13", 1'b0, F3_W, 32'h13, 32'd0, 32'd0, 1'b1);
    apply_stimulus(0, "sh 23", 1'b1, F3_H, 32'h23, 32'h00001234, 32'd0, 1'b1);
    apply_stimulus(0, "lw 20 mis", 1'b0, F3_W, 32'h20, 32'd0, 32'hBEEFAA44, 1'b0);
`else
    apply_stimulus(0, "lw 13", 1'b0, F3_W, 32'h13, 32'd0, 32'hDEADBEEF, 1'b0);
    apply_stimulus(0, "sh 23", 1'b1, F3_H, 32'h23, 32'h00001234, 32'd0, 1'b0);
    apply_stimulus(0, "lw 20 mis", 1'b0, F3_W, 32'h20, 32'd0, 32'h1234AA44, 1'b0);
`endif

    $display("[TB] wait states and held request");
    apply_stimulus(1, "ws sw 44", 1'b1, F3_W, 32'h44, 32'h0BADCAFE, 32'd0, 1'b0);
    apply_stimulus(1, "ws sw 40", 1'b1, F3_W, 32'h40, 32'hCAFEF00D, 32'd0, 1'b0);
    push_exp(32'hCAFEF00D, 1'b0);
    push_exp(32'h0BADCAFE, 1'b0);
    drive(1, 1'b0, F3_W, 32'h40, 32'd0);
    @(posedge clk); #1;
    drive(1, 1'b0, F3_W, 32'h44, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq("held busy ready", 32'(req_ready[1]), 32'd0);
      check_eq("held resp valid", 32'(resp_valid[1]), (i == 3) ? 32'd1 : 32'd0);
      if (i == 3) check_output(1, "held first");
      @(posedge clk); #1;
    end
    check_eq("held ready again", 32'(req_ready[1]), 32'd1);
    check_eq("held valid low", 32'(resp_valid[1]), 32'd0);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_resp(1, "held second");

    $display("[TB] reset during wait");
    drive(1, 1'b1, F3_W, 32'h48, 32'h600DD00D);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst ready", 32'(req_ready[1]), 32'd1);
    check_eq("rst valid", 32'(resp_valid[1]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("rst valid hold", 32'(resp_valid[1]), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("post rst valid", 32'(resp_valid[1]), 32'd0);
    end
    check_eq("post rst ready", 32'(req_ready[1]), 32'd1);
    apply_stimulus(1, "lw 48 after rst", 1'b0, F3_W, 32'h48, 32'd0, 32'h600DD00D, 1'b0);
    apply_stimulus(1, "lw 40 after rst", 1'b0, F3_W, 32'h40, 32'd0, 32'hCAFEF00D, 1'b0);
    apply_stimulus(0, "lw 10 after rst", 1'b0, F3_W, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

    check_eq("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
